// File: rtl/dso_acq_pkg.sv
// Shared types and helpers for the DSO acquisition sequencer.
package dso_acq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StPre,
    StArmed,
    StPost,
    StDone
  } acq_state_e;

  localparam int unsigned SettleStrobesDefault = 2;

  function automatic logic [31:0] tb_to_n(input logic [3:0] tb_sel);
    return 32'd1 << tb_sel;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: a low-to-high transition is reported one cycle later.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise
);

  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= sig_in;
      rise_q <= sig_in & ~prev_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/peak_decim_ctrl.sv
// Acquisition sequencer: settles the peak decimators, then fills the circular capture RAM
// with pre-trigger and post-trigger segments and reports the trigger address.
module peak_decim_ctrl
  import dso_acq_pkg::*;
#(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned SETTLE_STROBES = SettleStrobesDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        tb_sel,
  input  logic [ADDR_W-1:0] pretrig_len,
  input  logic              trig_in,
  input  logic              clken_in,
  output logic [31:0]       n_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy,
  output logic              done
);

  localparam int unsigned    CntW       = ADDR_W + 1;
  localparam logic [CntW-1:0] Depth      = CntW'(1) << ADDR_W;
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_STROBES - 1);

  acq_state_e        state_q, state_d;
  logic [31:0]       n_q;
  logic [ADDR_W-1:0] pre_len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] trig_addr_q;
  logic              wr_en_q;
  logic [CntW-1:0]   settle_cnt_q;
  logic [CntW-1:0]   seg_cnt_q;
  logic              trig_pend_q;
  logic              trig_rise;

  logic              accept;
  logic              write;
  logic              armed_hit;
  logic [CntW-1:0]   seg_next;
  logic [CntW-1:0]   pre_len_ext;
  logic [CntW-1:0]   post_len;

  rise_detect u_rise_detect (
    .clk   (clk),
    .rst   (rst),
    .sig_in(trig_in),
    .rise  (trig_rise)
  );

  // pretrig_len is ADDR_W wide, so its largest value is already DEPTH-1.
  assign pre_len_ext = {1'b0, pre_len_q};
  assign post_len    = Depth - pre_len_ext;
  assign seg_next    = seg_cnt_q + CntW'(1);
  assign accept      = start && !abort && (state_q == StIdle || state_q == StDone);
  assign armed_hit   = clken_in && (trig_rise || trig_pend_q);
  assign write       = !abort && clken_in &&
                       (state_q == StPre || state_q == StArmed || state_q == StPost);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: if (start) state_d = StSettle;
        StSettle: begin
          if (clken_in && settle_cnt_q == SettleLast) begin
            state_d = (pre_len_q == '0) ? StArmed : StPre;
          end
        end
        StPre:   if (clken_in && seg_next == pre_len_ext) state_d = StArmed;
        StArmed: if (armed_hit) state_d = (post_len == CntW'(1)) ? StDone : StPost;
        StPost:  if (clken_in && seg_next == post_len) state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StSettle, StPre, StArmed, StPost: busy = 1'b1;
      StDone:                           done = 1'b1;
      default:                          ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q          <= 32'd1;
      pre_len_q    <= '0;
      addr_q       <= '0;
      wr_addr_q    <= '0;
      trig_addr_q  <= '0;
      wr_en_q      <= 1'b0;
      settle_cnt_q <= '0;
      seg_cnt_q    <= '0;
      trig_pend_q  <= 1'b0;
    end else begin
      wr_en_q <= write;
      if (write) begin
        wr_addr_q <= addr_q;
        addr_q    <= addr_q + ADDR_W'(1);
      end
      if (accept) begin
        n_q          <= tb_to_n(tb_sel);
        pre_len_q    <= pretrig_len;
        settle_cnt_q <= '0;
        seg_cnt_q    <= '0;
        trig_pend_q  <= 1'b0;
      end
      if (!abort) begin
        case (state_q)
          StSettle: if (clken_in) settle_cnt_q <= settle_cnt_q + CntW'(1);
          StPre: begin
            if (clken_in) seg_cnt_q <= (seg_next == pre_len_ext) ? '0 : seg_next;
          end
          StArmed: begin
            // An edge seen between strobes is held until the next strobe.
            if (trig_rise) trig_pend_q <= 1'b1;
            if (armed_hit) begin
              trig_addr_q <= addr_q;
              seg_cnt_q   <= CntW'(1);
              trig_pend_q <= 1'b0;
            end
          end
          StPost:  if (clken_in) seg_cnt_q <= seg_next;
          default: ;
        endcase
      end
    end
  end

  assign n_out     = n_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_peak_decim_ctrl.sv
// Directed bench for peak_decim_ctrl with a write-address scoreboard (16-entry buffer).
module tb_peak_decim_ctrl;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [3:0]    tb_sel = '0;
  logic [AW-1:0] pretrig_len = '0;
  logic          trig_in = 1'b0;
  logic          clken_in = 1'b0;
  logic [31:0]   n_out;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] trig_addr;
  logic          busy;
  logic          done;

  int unsigned   errors = 0;
  int unsigned   checks = 0;
  logic [AW-1:0] sb[$];
  logic [AW-1:0] exp_addr = '0;
  logic [AW-1:0] trig_exp;

  peak_decim_ctrl #(
    .ADDR_W        (AW),
    .SETTLE_STROBES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .tb_sel     (tb_sel),
    .pretrig_len(pretrig_len),
    .trig_in    (trig_in),
    .clken_in   (clken_in),
    .n_out      (n_out),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .trig_addr  (trig_addr),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write the DUT makes must match the next address the bench expects.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        check("wr_addr", 32'(wr_addr), 32'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit wr, input int gap);
    clken_in = 1'b1;
    if (wr) begin
      sb.push_back(exp_addr);
      exp_addr = exp_addr + 1'b1;
    end
    tick();
    clken_in = 1'b0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic start_acq(input logic [3:0] tb, input logic [AW-1:0] pre);
    start       = 1'b1;
    tb_sel      = tb;
    pretrig_len = pre;
    tick();
    start = 1'b0;
  endtask

  task automatic edge_then_wait();
    trig_in = 1'b0;
    tick();
    trig_in = 1'b1;
    tick();
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    rst = 1'b0;
    check("rst_n_out", n_out, 32'd1);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_trig_addr", 32'(trig_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Settle discard plus full capture; trig_in high before ARMED must not trigger
    trig_in = 1'b1;
    start_acq(4'd3, 4'd5);
    check("n_out_tb3", n_out, 32'd8);
    check("busy_settle", 32'(busy), 32'd1);
    strobe(1'b0, 7);
    strobe(1'b0, 7);
    check("settle_no_wr", 32'(wr_en), 32'd0);
    strobe(1'b1, 0);
    check("first_wr_en", 32'(wr_en), 32'd1);
    check("first_wr_addr", 32'(wr_addr), 32'd0);
    for (int i = 0; i < 4; i++) strobe(1'b1, 1);
    for (int i = 0; i < 9; i++) strobe(1'b1, 1);
    check("no_trig_level_high", 32'(trig_addr), 32'd0);
    check("armed_busy", 32'(busy), 32'd1);
    edge_then_wait();
    trig_exp = exp_addr;
    strobe(1'b1, 1);
    check("trig_addr_cap", 32'(trig_addr), 32'(trig_exp));
    for (int i = 0; i < 9; i++) strobe(1'b1, 1);
    check("not_done_10post", 32'(done), 32'd0);
    start  = 1'b1;
    tb_sel = 4'd5;
    strobe(1'b1, 0);
    start = 1'b0;
    check("done_11post", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("n_hold_last_start", n_out, 32'd8);
    strobe(1'b0, 0);
    check("done_no_wr", 32'(wr_en), 32'd0);
    check("trig_addr_hold", 32'(trig_addr), 32'(trig_exp));

    // pretrig_len = 0: straight to ARMED, DEPTH post writes; start while busy ignored
    start_acq(4'd2, 4'd0);
    check("n_out_tb2", n_out, 32'd4);
    start_acq(4'd7, 4'd1);
    check("start_busy_ignored", n_out, 32'd4);
    strobe(1'b0, 1);
    strobe(1'b0, 1);
    strobe(1'b1, 1);
    edge_then_wait();
    trig_exp = exp_addr;
    strobe(1'b1, 1);
    check("trig_addr_pre0", 32'(trig_addr), 32'(trig_exp));
    for (int i = 0; i < 14; i++) strobe(1'b1, 0);
    check("not_done_15post", 32'(done), 32'd0);
    strobe(1'b1, 0);
    check("done_16post", 32'(done), 32'd1);

    // pretrig_len all-ones: one post write
    trig_in = 1'b0;
    start_acq(4'd15, 4'hF);
    check("n_out_tb15", n_out, 32'd32768);
    strobe(1'b0, 0);
    strobe(1'b0, 0);
    for (int i = 0; i < 15; i++) strobe(1'b1, 0);
    check("armed_after_15pre", 32'(busy), 32'd1);
    trig_in = 1'b1;
    tick();
    trig_exp = exp_addr;
    strobe(1'b1, 0);
    check("done_1post", 32'(done), 32'd1);
    check("trig_addr_max_pre", 32'(trig_addr), 32'(trig_exp));

    // abort + start in PRE
    start_acq(4'd1, 4'd3);
    check("n_out_tb1", n_out, 32'd2);
    strobe(1'b0, 0);
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    abort    = 1'b1;
    start    = 1'b1;
    tb_sel   = 4'd9;
    clken_in = 1'b1;
    tick();
    abort    = 1'b0;
    start    = 1'b0;
    clken_in = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_wr_en", 32'(wr_en), 32'd0);
    check("abort_n_hold", n_out, 32'd2);

    // Reset mid-POST
    trig_in = 1'b0;
    start_acq(4'd4, 4'd2);
    strobe(1'b0, 0);
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    strobe(1'b1, 0);
    edge_then_wait();
    strobe(1'b1, 0);
    strobe(1'b1, 0);
    strobe(1'b1, 0);
    check("post_busy", 32'(busy), 32'd1);
    rst      = 1'b1;
    clken_in = 1'b1;
    tick();
    rst      = 1'b0;
    clken_in = 1'b0;
    exp_addr = '0;
    check("mid_rst_n_out", n_out, 32'd1);
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("mid_rst_trig_addr", 32'(trig_addr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    strobe(1'b0, 1);
    check("idle_no_wr", 32'(wr_en), 32'd0);
    check("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
